// File: rtl/core_mem_port.sv
// core_mem_port: serves the core's inst/data accesses one at a time on a single-outstanding bus
// Ports: CLK/RST (synchronous, active-low); INST_* instruction read port; DATA_* data read
// and write ports; MEM_WAIT stall to the core; BUS_* backing bus (REQ/READY handshake,
// read data returned later on RVALID).
module core_mem_port #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  INST_RDEN,
    input  logic [31:0]           INST_RIADDR,
    output logic [31:0]           INST_ROADDR,
    output logic                  INST_RVALID,
    output logic [31:0]           INST_RDATA,
    input  logic                  DATA_RDEN,
    input  logic [31:0]           DATA_RIADDR,
    output logic [31:0]           DATA_ROADDR,
    output logic                  DATA_RVALID,
    output logic [31:0]           DATA_RDATA,
    input  logic                  DATA_WREN,
    input  logic [31:0]           DATA_WADDR,
    input  logic [31:0]           DATA_WDATA,
    output logic                  MEM_WAIT,
    output logic                  BUS_REQ,
    output logic                  BUS_WE,
    output logic [ADDR_WIDTH-1:0] BUS_ADDR,
    output logic [31:0]           BUS_WDATA,
    input  logic                  BUS_READY,
    input  logic                  BUS_RVALID,
    input  logic [31:0]           BUS_RDATA
);
    typedef enum logic [2:0] {IDLE, WR, DRD, IRD, DONE} state_t;
    state_t state;
    logic pend_drd, pend_ird, rd_wait;
    logic [31:0] drd_addr, ird_addr, launch_addr;
    logic any_req, capture, wr_done, drd_done, ird_done, go_wr, go_drd, go_ird, go_done;
    logic unused_bits;
    assign any_req  = DATA_WREN | DATA_RDEN | INST_RDEN;
    assign capture  = state == IDLE && any_req;
    assign wr_done  = state == WR && BUS_READY;
    // read data only counts once the request has been accepted
    assign drd_done = state == DRD && rd_wait && BUS_RVALID;
    assign ird_done = state == IRD && rd_wait && BUS_RVALID;
    // launch decisions: from IDLE the live inputs choose, afterwards the captured pending set
    assign go_wr    = capture && DATA_WREN;
    assign go_drd   = capture ? !DATA_WREN && DATA_RDEN : wr_done && pend_drd;
    assign go_ird   = capture ? !DATA_WREN && !DATA_RDEN : ((wr_done && !pend_drd) || drd_done) && pend_ird;
    assign go_done  = ird_done || (((wr_done && !pend_drd) || drd_done) && !pend_ird);
    assign launch_addr = go_wr ? DATA_WADDR :
                         go_drd ? (capture ? DATA_RIADDR : drd_addr) :
                         (capture ? INST_RIADDR : ird_addr);
    assign unused_bits = ^launch_addr[1:0];
    assign MEM_WAIT = RST && (state == WR || state == DRD || state == IRD || capture);
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state       <= IDLE;
            pend_drd    <= 1'b0;
            pend_ird    <= 1'b0;
            rd_wait     <= 1'b0;
            drd_addr    <= '0;
            ird_addr    <= '0;
            BUS_REQ     <= 1'b0;
            BUS_WE      <= 1'b0;
            BUS_ADDR    <= '0;
            BUS_WDATA   <= '0;
            INST_RVALID <= 1'b0;
            INST_ROADDR <= '0;
            INST_RDATA  <= '0;
            DATA_RVALID <= 1'b0;
            DATA_ROADDR <= '0;
            DATA_RDATA  <= '0;
        end else begin
            state <= go_wr ? WR : go_drd ? DRD : go_ird ? IRD : go_done ? DONE :
                     state == DONE ? IDLE : state;
            if (capture) begin
                pend_drd    <= DATA_RDEN;
                pend_ird    <= INST_RDEN;
                drd_addr    <= DATA_RIADDR;
                ird_addr    <= INST_RIADDR;
                INST_RVALID <= 1'b0;
                DATA_RVALID <= 1'b0;
                if (DATA_WREN)
                    BUS_WDATA <= DATA_WDATA;
            end
            if (go_wr || go_drd || go_ird) begin
                BUS_REQ  <= 1'b1;
                BUS_WE   <= go_wr;
                BUS_ADDR <= {launch_addr[ADDR_WIDTH-1:2], 2'b00};
            end else if (BUS_READY) begin
                BUS_REQ <= 1'b0;
            end
            // set once a read is accepted, held until its data returns
            rd_wait <= (state == DRD || state == IRD) && (rd_wait ? !BUS_RVALID : BUS_REQ && BUS_READY);
            if (drd_done) begin
                DATA_RDATA  <= BUS_RDATA;
                DATA_ROADDR <= drd_addr;
                DATA_RVALID <= 1'b1;
            end
            if (ird_done) begin
                INST_RDATA  <= BUS_RDATA;
                INST_ROADDR <= ird_addr;
                INST_RVALID <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_core_mem_port.sv
// tb_core_mem_port: directed scenarios for core_mem_port against a small bus/memory model
module tb_core_mem_port;
    logic CLK = 1'b0, RST = 1'b0;
    logic INST_RDEN, DATA_RDEN, DATA_WREN;
    logic [31:0] INST_RIADDR, DATA_RIADDR, DATA_WADDR, DATA_WDATA;
    logic [31:0] INST_ROADDR, INST_RDATA, DATA_ROADDR, DATA_RDATA;
    logic INST_RVALID, DATA_RVALID, MEM_WAIT;
    logic BUS_REQ, BUS_WE, BUS_READY, BUS_RVALID;
    logic [31:0] BUS_ADDR, BUS_WDATA, BUS_RDATA;

    int n_vec = 0, n_err = 0;
    int ready_delay = 0;
    int wait_cnt = 0;
    int n_log = 0;
    logic rv_pend = 1'b0;
    logic [31:0] rv_data = '0;
    logic [31:0] mem [256];
    bit wr_seen [256];
    logic log_we [64];
    logic [31:0] log_addr [64];
    logic [31:0] log_wdata [64];

    always #5 CLK = ~CLK;

    core_mem_port dut (
        .CLK(CLK), .RST(RST),
        .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_ROADDR(INST_ROADDR),
        .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
        .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_ROADDR(DATA_ROADDR),
        .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
        .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR), .DATA_WDATA(DATA_WDATA),
        .MEM_WAIT(MEM_WAIT),
        .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
        .BUS_READY(BUS_READY), .BUS_RVALID(BUS_RVALID), .BUS_RDATA(BUS_RDATA)
    );

    function automatic logic [31:0] init_word(input logic [7:0] i);
        return (i == 8'd0) ? 32'h0000_0013 : (32'hC0DE_0000 | {24'h0, i});
    endfunction

    // bus model: READY after ready_delay request cycles, read data one cycle after acceptance
    assign BUS_READY  = BUS_REQ && (wait_cnt >= ready_delay);
    assign BUS_RVALID = rv_pend;
    assign BUS_RDATA  = rv_data;

    always @(posedge CLK) begin
        if (!RST) begin
            wait_cnt <= 0;
            rv_pend  <= 1'b0;
        end else begin
            rv_pend <= BUS_READY && !BUS_WE;
            if (BUS_READY) begin
                wait_cnt <= 0;
                log_we[n_log % 64]    <= BUS_WE;
                log_addr[n_log % 64]  <= BUS_ADDR;
                log_wdata[n_log % 64] <= BUS_WDATA;
                n_log <= n_log + 1;
                if (BUS_WE) begin
                    mem[BUS_ADDR[9:2]]     <= BUS_WDATA;
                    wr_seen[BUS_ADDR[9:2]] <= 1'b1;
                end else begin
                    rv_data <= wr_seen[BUS_ADDR[9:2]] ? mem[BUS_ADDR[9:2]] : init_word(BUS_ADDR[9:2]);
                end
            end else if (BUS_REQ) begin
                wait_cnt <= wait_cnt + 1;
            end
        end
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic release_req;
        DATA_WREN = 1'b0;
        DATA_RDEN = 1'b0;
        INST_RDEN = 1'b0;
    endtask

    // drive a request set and return the number of MEM_WAIT-high cycles; ends in the DONE cycle
    task automatic issue(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                         input logic dr, input logic [31:0] da,
                         input logic ir, input logic [31:0] ia, output int cyc);
        DATA_WREN = wr; DATA_WADDR = wa; DATA_WDATA = wd;
        DATA_RDEN = dr; DATA_RIADDR = da;
        INST_RDEN = ir; INST_RIADDR = ia;
        cyc = 0;
        #1;
        while (MEM_WAIT && cyc < 200) begin
            cyc++;
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic test_reset;
        RST = 1'b0;
        release_req;
        DATA_WADDR = '0; DATA_WDATA = '0; DATA_RIADDR = '0; INST_RIADDR = '0;
        repeat (2) @(posedge CLK);
        #1;
        INST_RDEN = 1'b1;
        #1;
        n_vec++;
        if (MEM_WAIT !== 1'b0) begin n_err++; $display("FAIL reset_mem_wait: got %b expected 0", MEM_WAIT); end
        n_vec++;
        if ({BUS_REQ, BUS_WE, INST_RVALID, DATA_RVALID} !== 4'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 0000", {BUS_REQ, BUS_WE, INST_RVALID, DATA_RVALID});
        end
        n_vec++;
        if ({BUS_ADDR, BUS_WDATA} !== 64'h0) begin n_err++; $display("FAIL reset_bus: got %h expected 0", {BUS_ADDR, BUS_WDATA}); end
        n_vec++;
        if ({INST_ROADDR, INST_RDATA, DATA_ROADDR, DATA_RDATA} !== 128'h0) begin
            n_err++; $display("FAIL reset_resp: got %h expected 0", {INST_ROADDR, INST_RDATA, DATA_ROADDR, DATA_RDATA});
        end
        release_req;
        RST = 1'b1;
        step;
    endtask

    task automatic test_inst_read;
        int cyc, base;
        base = n_log;
        issue(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h2000_0000, cyc);
        n_vec++;
        if (cyc !== 3) begin n_err++; $display("FAIL ird_wait_cycles: got %0d expected 3", cyc); end
        n_vec++;
        if ({INST_RVALID, DATA_RVALID} !== 2'b10) begin n_err++; $display("FAIL ird_rvalids: got %b expected 10", {INST_RVALID, DATA_RVALID}); end
        n_vec++;
        if (INST_RDATA !== 32'h0000_0013) begin n_err++; $display("FAIL ird_rdata: got %h expected 00000013", INST_RDATA); end
        n_vec++;
        if (INST_ROADDR !== 32'h2000_0000) begin n_err++; $display("FAIL ird_roaddr: got %h expected 20000000", INST_ROADDR); end
        n_vec++;
        if (n_log - base !== 1 || log_we[base % 64] !== 1'b0 || log_addr[base % 64] !== 32'h2000_0000) begin
            n_err++; $display("FAIL ird_bus: got n=%0d we=%b addr=%h expected n=1 we=0 addr=20000000",
                              n_log - base, log_we[base % 64], log_addr[base % 64]);
        end
        release_req;
        step;
    endtask

    task automatic test_write_only;
        int cyc, base;
        base = n_log;
        issue(1'b1, 32'h2000_0041, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 32'h0, cyc);
        n_vec++;
        if (cyc !== 2) begin n_err++; $display("FAIL wr_wait_cycles: got %0d expected 2", cyc); end
        n_vec++;
        if ({INST_RVALID, DATA_RVALID} !== 2'b00) begin n_err++; $display("FAIL wr_rvalids: got %b expected 00", {INST_RVALID, DATA_RVALID}); end
        n_vec++;
        if (n_log - base !== 1 || log_we[base % 64] !== 1'b1 || log_addr[base % 64] !== 32'h2000_0040
            || log_wdata[base % 64] !== 32'h1234_5678) begin
            n_err++; $display("FAIL wr_bus: got n=%0d we=%b addr=%h wdata=%h expected n=1 we=1 addr=20000040 wdata=12345678",
                              n_log - base, log_we[base % 64], log_addr[base % 64], log_wdata[base % 64]);
        end
        release_req;
        step;
    endtask

    task automatic test_combined;
        int cyc, base;
        base = n_log;
        issue(1'b1, 32'h2000_0100, 32'hDEAD_BEEF, 1'b1, 32'h2000_0102, 1'b1, 32'h2000_0004, cyc);
        n_vec++;
        if (cyc !== 6) begin n_err++; $display("FAIL all_wait_cycles: got %0d expected 6", cyc); end
        n_vec++;
        if (n_log - base !== 3) begin n_err++; $display("FAIL all_bus_count: got %0d expected 3", n_log - base); end
        n_vec++;
        if ({log_we[base % 64], log_we[(base + 1) % 64], log_we[(base + 2) % 64]} !== 3'b100) begin
            n_err++; $display("FAIL all_bus_order: got %b expected 100",
                              {log_we[base % 64], log_we[(base + 1) % 64], log_we[(base + 2) % 64]});
        end
        n_vec++;
        if ({log_addr[base % 64], log_addr[(base + 1) % 64], log_addr[(base + 2) % 64]} !== {32'h2000_0100, 32'h2000_0100, 32'h2000_0004}) begin
            n_err++; $display("FAIL all_bus_addr: got %h %h %h expected 20000100 20000100 20000004",
                              log_addr[base % 64], log_addr[(base + 1) % 64], log_addr[(base + 2) % 64]);
        end
        n_vec++;
        if ({DATA_RVALID, DATA_RDATA, DATA_ROADDR} !== {1'b1, 32'hDEAD_BEEF, 32'h2000_0102}) begin
            n_err++; $display("FAIL all_data_resp: got %b %h %h expected 1 deadbeef 20000102", DATA_RVALID, DATA_RDATA, DATA_ROADDR);
        end
        n_vec++;
        if ({INST_RVALID, INST_RDATA, INST_ROADDR} !== {1'b1, 32'hC0DE_0001, 32'h2000_0004}) begin
            n_err++; $display("FAIL all_inst_resp: got %b %h %h expected 1 c0de0001 20000004", INST_RVALID, INST_RDATA, INST_ROADDR);
        end
        release_req;
        step;
    endtask

    task automatic test_ready_stall;
        ready_delay = 5;
        DATA_RDEN = 1'b1;
        DATA_RIADDR = 32'h2000_0043;
        @(posedge CLK);
        #2;
        for (int k = 0; k < 6; k++) begin
            n_vec++;
            if ({BUS_REQ, MEM_WAIT, BUS_ADDR} !== {1'b1, 1'b1, 32'h2000_0040}) begin
                n_err++; $display("FAIL stall_hold_%0d: got req=%b wait=%b addr=%h expected req=1 wait=1 addr=20000040",
                                  k, BUS_REQ, MEM_WAIT, BUS_ADDR);
            end
            @(posedge CLK);
            #2;
        end
        n_vec++;
        if ({BUS_REQ, MEM_WAIT, DATA_RVALID} !== 3'b010) begin
            n_err++; $display("FAIL stall_rdwait: got req/wait/rvalid=%b expected 010", {BUS_REQ, MEM_WAIT, DATA_RVALID});
        end
        @(posedge CLK);
        #2;
        n_vec++;
        if ({MEM_WAIT, DATA_RVALID, DATA_RDATA, DATA_ROADDR} !== {1'b0, 1'b1, 32'h1234_5678, 32'h2000_0043}) begin
            n_err++; $display("FAIL stall_done: got wait=%b rvalid=%b data=%h addr=%h expected 0 1 12345678 20000043",
                              MEM_WAIT, DATA_RVALID, DATA_RDATA, DATA_ROADDR);
        end
        ready_delay = 0;
        release_req;
        step;
    endtask

    task automatic test_held_request;
        int cyc;
        issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h2000_0100, 1'b0, 32'h0, cyc);
        n_vec++;
        if (cyc !== 3 || DATA_RVALID !== 1'b1) begin
            n_err++; $display("FAIL held_first: got cycles=%0d rvalid=%b expected 3 1", cyc, DATA_RVALID);
        end
        @(posedge CLK);
        #2;
        n_vec++;
        if ({BUS_REQ, MEM_WAIT, DATA_RVALID} !== 3'b011) begin
            n_err++; $display("FAIL held_done_plus1: got req/wait/rvalid=%b expected 011", {BUS_REQ, MEM_WAIT, DATA_RVALID});
        end
        @(posedge CLK);
        #2;
        n_vec++;
        if ({BUS_REQ, DATA_RVALID} !== 2'b10) begin
            n_err++; $display("FAIL held_done_plus2: got req/rvalid=%b expected 10", {BUS_REQ, DATA_RVALID});
        end
        repeat (2) @(posedge CLK);
        #2;
        n_vec++;
        if ({MEM_WAIT, DATA_RVALID, DATA_RDATA} !== {1'b0, 1'b1, 32'hDEAD_BEEF}) begin
            n_err++; $display("FAIL held_second: got wait=%b rvalid=%b data=%h expected 0 1 deadbeef", MEM_WAIT, DATA_RVALID, DATA_RDATA);
        end
        release_req;
        step;
    endtask

    task automatic test_reset_mid;
        int cyc;
        INST_RDEN = 1'b1;
        INST_RIADDR = 32'h2000_0004;
        @(posedge CLK);
        #2;
        n_vec++;
        if ({BUS_REQ, BUS_READY} !== 2'b11) begin n_err++; $display("FAIL rstmid_req: got req/ready=%b expected 11", {BUS_REQ, BUS_READY}); end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        release_req;
        #1;
        n_vec++;
        if (MEM_WAIT !== 1'b0) begin n_err++; $display("FAIL rstmid_wait_low: got %b expected 0", MEM_WAIT); end
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        n_vec++;
        if ({INST_RVALID, BUS_REQ, MEM_WAIT} !== 3'b000) begin
            n_err++; $display("FAIL rstmid_after: got rvalid/req/wait=%b expected 000", {INST_RVALID, BUS_REQ, MEM_WAIT});
        end
        step;
        issue(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h2000_0000, cyc);
        n_vec++;
        if (cyc !== 3 || {INST_RVALID, INST_RDATA} !== {1'b1, 32'h0000_0013}) begin
            n_err++; $display("FAIL rstmid_next: got cycles=%0d rvalid=%b data=%h expected 3 1 00000013", cyc, INST_RVALID, INST_RDATA);
        end
        release_req;
        step;
    endtask

    initial begin
        test_reset;
        test_inst_read;
        test_write_only;
        test_combined;
        test_ready_stall;
        test_held_request;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
